// File: rtl/branch_predict_resolve_if.sv
// Bundle between the fetch/execute pipeline and the branch predictor/resolver.
// master = pipeline side, slave = predictor side.
interface branch_predict_resolve_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pcF;
    logic            predTakenF;
    logic [XLEN-1:0] predTargetF;
    logic            validE;
    logic            stallE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcPlus4E;
    logic [XLEN-1:0] targetE;
    logic [2:0]      branchE;
    logic [1:0]      jumpE;
    logic            zero;
    logic            lt;
    logic            ltu;
    logic            predTakenE;
    logic [XLEN-1:0] predTargetE;
    logic            redirectE;
    logic [XLEN-1:0] redirectPcE;
    logic            flushDE;
    logic [31:0]     brCount;
    logic [31:0]     mispCount;

    modport master (
        output pcF, validE, stallE, pcE, pcPlus4E, targetE, branchE, jumpE,
               zero, lt, ltu, predTakenE, predTargetE,
        input  predTakenF, predTargetF, redirectE, redirectPcE, flushDE,
               brCount, mispCount
    );

    modport slave (
        input  pcF, validE, stallE, pcE, pcPlus4E, targetE, branchE, jumpE,
               zero, lt, ltu, predTakenE, predTargetE,
        output predTakenF, predTargetF, redirectE, redirectPcE, flushDE,
               brCount, mispCount
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Direct-mapped BTB + 2-bit BHT predictor with E-stage branch resolution and redirect.
// Optional perf counters (brCount/mispCount) enabled by defining BPU_PERF_CNT_EN.
module branch_predict_resolve #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predict_resolve_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q   [ENTRIES];
    logic             valid_d   [ENTRIES];
    logic [TAG_W-1:0] tag_q     [ENTRIES];
    logic [TAG_W-1:0] tag_d     [ENTRIES];
    logic [XLEN-1:0]  target_q  [ENTRIES];
    logic [XLEN-1:0]  target_d  [ENTRIES];
    logic             is_jump_q [ENTRIES];
    logic             is_jump_d [ENTRIES];
    logic [CNT_W-1:0] cnt_q     [ENTRIES];
    logic [CNT_W-1:0] cnt_d     [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_e;
    logic             hit_f;
    logic             pred_taken_f;

    logic             is_cond_e;
    logic             is_jump_op_e;
    logic             taken_e;
    logic             ctrl_e;
    logic             redirect_e;
    logic [XLEN-1:0]  redirect_pc_e;
    logic             upd_e;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pcF[1:0], bus.pcE[1:0]};

    assign idx_f = bus.pcF[IDX_W+1:2];
    assign tag_f = bus.pcF[XLEN-1:IDX_W+2];
    assign idx_e = bus.pcE[IDX_W+1:2];
    assign tag_e = bus.pcE[XLEN-1:IDX_W+2];

    // Fetch-side lookup reads the registered arrays directly: a same-cycle E write is not bypassed.
    always_comb begin
        hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        pred_taken_f     = hit_f && (is_jump_q[idx_f] || cnt_q[idx_f][CNT_W-1]);
        bus.predTakenF   = pred_taken_f;
        bus.predTargetF  = pred_taken_f ? target_q[idx_f] : '0;
    end

    always_comb begin
        is_cond_e    = (bus.branchE != 3'b000) && (bus.branchE != 3'b111);
        is_jump_op_e = (bus.branchE == 3'b000) &&
                       ((bus.jumpE == 2'b01) || (bus.jumpE == 2'b10));
        unique case (bus.branchE)
            3'b000:  taken_e = is_jump_op_e;
            3'b001:  taken_e = bus.zero;
            3'b010:  taken_e = !bus.zero;
            3'b011:  taken_e = bus.lt;
            3'b100:  taken_e = !bus.lt;
            3'b101:  taken_e = bus.ltu;
            3'b110:  taken_e = !bus.ltu;
            default: taken_e = 1'b0;
        endcase
        ctrl_e = bus.validE && (is_cond_e || is_jump_op_e);

        redirect_e    = 1'b0;
        redirect_pc_e = bus.pcPlus4E;
        if (bus.validE) begin
            if (taken_e && (!bus.predTakenE || (bus.predTargetE != bus.targetE))) begin
                redirect_e    = 1'b1;
                redirect_pc_e = bus.targetE;
            end else if (!taken_e && bus.predTakenE) begin
                redirect_e    = 1'b1;
            end
        end
        bus.redirectE   = redirect_e;
        bus.redirectPcE = redirect_pc_e;
        bus.flushDE     = redirect_e;
    end

    assign upd_e = bus.validE && !bus.stallE;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]   = valid_q[i];
            tag_d[i]     = tag_q[i];
            target_d[i]  = target_q[i];
            is_jump_d[i] = is_jump_q[i];
            cnt_d[i]     = cnt_q[i];
        end
        if (upd_e) begin
            // Counters train only on conditional branches; jumps rely on isJump instead.
            if (is_cond_e) begin
                if (taken_e && (cnt_q[idx_e] != {CNT_W{1'b1}}))
                    cnt_d[idx_e] = cnt_q[idx_e] + CNT_W'(1);
                else if (!taken_e && (cnt_q[idx_e] != '0))
                    cnt_d[idx_e] = cnt_q[idx_e] - CNT_W'(1);
            end
            if (ctrl_e && taken_e) begin
                valid_d[idx_e]   = 1'b1;
                tag_d[idx_e]     = tag_e;
                target_d[idx_e]  = bus.targetE;
                is_jump_d[idx_e] = (bus.branchE == 3'b000);
            end else if (!ctrl_e && redirect_e) begin
                // A non-control op hit in the BTB through index aliasing; drop the stale entry.
                valid_d[idx_e] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                cnt_q[i]     <= CNT_W'(1);
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= valid_d[i];
                tag_q[i]     <= tag_d[i];
                target_q[i]  <= target_d[i];
                is_jump_q[i] <= is_jump_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_count_q;
    logic [31:0] br_count_d;
    logic [31:0] misp_count_q;
    logic [31:0] misp_count_d;

    always_comb begin
        br_count_d   = br_count_q;
        misp_count_d = misp_count_q;
        if (upd_e && ctrl_e)
            br_count_d = br_count_q + 32'd1;
        if (upd_e && redirect_e)
            misp_count_d = misp_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q   <= '0;
            misp_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            misp_count_q <= misp_count_d;
        end
    end

    assign bus.brCount   = br_count_q;
    assign bus.mispCount = misp_count_q;
`else
    assign bus.brCount   = '0;
    assign bus.mispCount = '0;
`endif
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed-vector bench for branch_predict_resolve: stimulus pushes expectations into a
// scoreboard queue, a negedge monitor pops and compares the DUT outputs.
module tb_branch_predict_resolve;
    logic clk;
    logic rst_n;

    branch_predict_resolve_if #(.XLEN(32)) bus ();

    branch_predict_resolve #(
        .XLEN(32),
        .ENTRIES(64),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic [31:0] e_br;
        logic [31:0] e_mi;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [31:0] mdl_br = 0;
    logic [31:0] mdl_mi = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.nm, "predTakenF",  {31'd0, bus.predTakenF}, {31'd0, e.e_pt});
            chk(e.nm, "predTargetF", bus.predTargetF,         e.e_ptg);
            chk(e.nm, "redirectE",   {31'd0, bus.redirectE},  {31'd0, e.e_rd});
            chk(e.nm, "flushDE",     {31'd0, bus.flushDE},    {31'd0, e.e_rd});
            chk(e.nm, "redirectPcE", bus.redirectPcE,         e.e_rpc);
            chk(e.nm, "brCount",     bus.brCount,             e.e_br);
            chk(e.nm, "mispCount",   bus.mispCount,           e.e_mi);
            $display("vec %-12s pt=%0d ptg=%h rd=%0d rpc=%h br=%0d mi=%0d", e.nm,
                     bus.predTakenF, bus.predTargetF, bus.redirectE, bus.redirectPcE,
                     bus.brCount, bus.mispCount);
        end
    end

    // One cycle of stimulus; ctrl marks a real control op so the counter model can follow.
    task automatic row(input string nm, input bit rs, input logic [31:0] pcf,
                       input bit v, input bit st, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic [2:0] br, input logic [1:0] jp, input bit z, input bit l,
                       input bit lu, input bit pte, input logic [31:0] ptge, input bit ctrl,
                       input bit e_pt, input logic [31:0] e_ptg, input bit e_rd,
                       input logic [31:0] e_rpc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rs;
        bus.pcF         = pcf;
        bus.validE      = v;
        bus.stallE      = st;
        bus.pcE         = pce;
        bus.pcPlus4E    = pce + 32'd4;
        bus.targetE     = tgt;
        bus.branchE     = br;
        bus.jumpE       = jp;
        bus.zero        = z;
        bus.lt          = l;
        bus.ltu         = lu;
        bus.predTakenE  = pte;
        bus.predTargetE = ptge;
        if (!rs) begin
            mdl_br = 0;
            mdl_mi = 0;
        end
        e.nm    = nm;
        e.e_pt  = e_pt;
        e.e_ptg = e_ptg;
        e.e_rd  = e_rd;
        e.e_rpc = e_rpc;
`ifdef BPU_PERF_CNT_EN
        e.e_br  = mdl_br;
        e.e_mi  = mdl_mi;
`else
        e.e_br  = 32'd0;
        e.e_mi  = 32'd0;
`endif
        sb_q.push_back(e);
        if (rs && v && !st) begin
            if (ctrl) mdl_br = mdl_br + 32'd1;
            if (e_rd) mdl_mi = mdl_mi + 32'd1;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.pcF         = '0;
        bus.validE      = 1'b0;
        bus.stallE      = 1'b0;
        bus.pcE         = '0;
        bus.pcPlus4E    = 32'd4;
        bus.targetE     = '0;
        bus.branchE     = 3'b000;
        bus.jumpE       = 2'b00;
        bus.zero        = 1'b0;
        bus.lt          = 1'b0;
        bus.ltu         = 1'b0;
        bus.predTakenE  = 1'b0;
        bus.predTargetE = '0;
        repeat (3) @(posedge clk);

        //   name            rs pcF    v st pcE    tgt    br jp z l lu pte ptgE  ctl  ePt ePtg   eRd eRpc
        row("rst_pred",      1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);
        row("beq_t1",        1, 32'h100, 1, 0, 32'h100, 32'h140, 1, 0, 1, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h140);
        row("beq_trained",   1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h140, 0, 32'h4);
        row("beq_nt1",       1, 32'h100, 1, 0, 32'h100, 32'h140, 1, 0, 0, 0, 0, 1, 32'h140, 1, 1, 32'h140, 1, 32'h104);
        row("beq_nt2",       1, 32'h100, 1, 0, 32'h100, 32'h140, 1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h104);
        row("beq_nt3",       1, 32'h100, 1, 0, 32'h100, 32'h140, 1, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h104);
        row("beq_sat0",      1, 32'h100, 1, 0, 32'h100, 32'h140, 1, 0, 1, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h140);
        row("sat_chk",       1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);
        row("jalr1",         1, 32'h200, 1, 0, 32'h200, 32'h300, 0, 2, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h300);
        row("jalr_pred",     1, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h300, 0, 32'h4);
        row("jalr2",         1, 32'h100, 1, 0, 32'h200, 32'h380, 0, 2, 0, 0, 0, 1, 32'h300, 1, 0, 32'h0,   1, 32'h380);
        row("jalr_tgt",      1, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h380, 0, 32'h4);
        row("jalr3",         1, 32'h200, 1, 0, 32'h200, 32'h380, 0, 2, 0, 0, 0, 1, 32'h380, 1, 1, 32'h380, 0, 32'h204);
        row("jal1",          1, 32'h308, 1, 0, 32'h308, 32'h400, 0, 1, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h400);
        row("jal_pred",      1, 32'h308, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h400, 0, 32'h4);
        row("bltu_nt",       1, 32'h410, 1, 0, 32'h410, 32'h500, 5, 0, 0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h414);
        row("bge_stall",     1, 32'h420, 1, 1, 32'h420, 32'h600, 4, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h600);
        row("stall_hold",    1, 32'h420, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);
        row("bge_t",         1, 32'h420, 1, 0, 32'h420, 32'h600, 4, 0, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h600);
        row("bge_pred",      1, 32'h420, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 32'h600, 0, 32'h4);
        row("bne_nt",        1, 32'h100, 1, 0, 32'h430, 32'h4c0, 2, 0, 1, 0, 0, 1, 32'h999, 1, 0, 32'h0,   1, 32'h434);
        row("bgeu_t",        1, 32'h440, 1, 0, 32'h440, 32'h480, 6, 0, 0, 0, 0, 1, 32'h480, 1, 0, 32'h0,   0, 32'h444);
        row("blt_tgt",       1, 32'h440, 1, 0, 32'h450, 32'h700, 3, 0, 0, 1, 0, 1, 32'h704, 1, 1, 32'h480, 1, 32'h700);
        row("alias_inv",     1, 32'h200, 1, 0, 32'h200, 32'h0,   7, 0, 0, 0, 0, 1, 32'h380, 0, 1, 32'h380, 1, 32'h204);
        row("alias_chk",     1, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);
        row("nonctrl_jp3",   1, 32'h200, 1, 0, 32'h500, 32'h0,   0, 3, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h504);
        row("invalid_gate",  1, 32'h308, 0, 0, 32'h100, 32'h140, 1, 0, 1, 0, 0, 1, 32'h140, 1, 1, 32'h400, 0, 32'h104);
        row("rst_mid",       0, 32'h308, 1, 0, 32'h308, 32'h400, 0, 1, 0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h400);
        row("rst_after",     1, 32'h308, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);
        row("cnt_reset",     1, 32'h440, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4);

        repeat (3) @(posedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the E-stage branch controller.
- Adds a direct-mapped BTB with 2-bit saturating BHT counters, read at F for prediction and updated at E on resolution.
- Resolves all RV32I conditional branches (BEQ, BNE, BLT, BGE, BLTU, BGEU) plus JAL/JALR.
- Emits a redirect with the corrected PC and a flush whenever prediction and outcome disagree.

Parameters:
- XLEN, 32: PC and target width.
- ENTRIES, 64: BTB/BHT entries; power of two, at least 4. IDX_W = log2(ENTRIES).
- CNT_W, 2: BHT counter width, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pcF  in  XLEN  fetch PC.
- predTakenF  out  1  predict taken at F.
- predTargetF  out  XLEN  predicted target; 0 when predTakenF=0.
- validE  in  1  E holds a real instruction.
- stallE  in  1  E frozen this cycle.
- pcE  in  XLEN  PC of E instruction.
- pcPlus4E  in  XLEN  fall-through PC.
- targetE  in  XLEN  resolved target (PC+imm, or ALU result for JALR).
- branchE  in  3  000 generalJump, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved.
- jumpE  in  2  00 none, 01 JAL, 10 JALR, 11 none.
- zero  in  1  ALU equal.
- lt  in  1  signed less-than.
- ltu  in  1  unsigned less-than.
- predTakenE  in  1  predTakenF piped to E.
- predTargetE  in  XLEN  predTargetF piped to E.
- redirectE  out  1  mispredict; fetch from redirectPcE.
- redirectPcE  out  XLEN  corrected PC.
- flushDE  out  1  flush D and E-next; equals redirectE.
- brCount  out  32  resolved control ops.
- mispCount  out  32  mispredicts.

Behaviour:
- Storage per entry: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], isJump, cnt[CNT_W]. Index = pc[IDX_W+1:2].
- Async reset: all valid=0; all cnt=01 (weakly not-taken, MSB=0, LSB=1 for any CNT_W); perf counters 0. Reset mid-operation discards any pending update.
- F prediction, combinational, 0-cycle:
  - hit = valid && tag match.
  - predTakenF = hit && (isJump || cnt MSB).
  - predTargetF = stored target when predTakenF, else 0.
- E outcome, combinational:
  - taken per branchE: generalJump → jumpE is 01 or 10; BEQ → zero; BNE → !zero; BLT → lt; BGE → !lt; BLTU → ltu; BGEU → !ltu; 111 → 0 (not a control op).
  - ctrl = validE && (branchE in 001..110, or branchE=000 with jumpE in {01,10}).
- Redirect (all conditions gated by validE; validE=0 forces redirectE=0):
  - taken && (!predTakenE || predTargetE != targetE) → redirectE=1, redirectPcE=targetE.
  - !taken && predTakenE → redirectE=1, redirectPcE=pcPlus4E. Covers BTB alias on a non-control op.
  - Otherwise redirectE=0, redirectPcE=pcPlus4E.
- Update, registered at posedge, only when validE && !stallE:
  - Conditional branch: cnt saturating +1 if taken, −1 if not; no wrap at 11 or 00.
  - Any ctrl with taken=1: write valid=1, tag, target=targetE, isJump = (branchE==000).
  - Not-taken conditional: BTB entry untouched.
  - Non-ctrl with redirect (alias): clear valid at pcE index.
  - JAL/JALR: counter not modified.
- Simultaneous F read and E write to the same index: F sees the pre-edge (old) contents; no bypass.
- stallE=1 holds all state; redirectE is still driven combinationally.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- Defined: brCount increments per updating ctrl op; mispCount increments per updating redirect. Both wrap modulo 2^32.
- Undefined: both tied to 0; no counter flops.

Test Plan:
- Reset, then pcF=0x100 → predTakenF=0, predTargetF=0; every entry reads cnt=01.
- BEQ at 0x100, zero=1, targetE=0x140, predTakenE=0 → redirectE=1, redirectPcE=0x140. Next cycle pcF=0x100 → predTakenF=1, predTargetF=0x140 (cnt=10).
- Same BEQ twice with zero=0 after training → first: redirectE=1, redirectPcE=0x104, cnt 10→01; second: predTakenF=0, no redirect, cnt 01→00, third not-taken stays 00.
- JALR at 0x200, first targetE=0x300, then 0x380 with predTargetE=0x300 → second redirects to 0x380; BTB target becomes 0x380.
- BLTU with lt=1, ltu=0 → not taken; BGE with lt=0 → taken. stallE=1 on the same cycle → no state change.
- Alias: 0x100 and 0x100+4*ENTRIES; non-ctrl op with predTakenE=1 → redirect to pcPlus4E, entry invalidated. With BPU_PERF_CNT_EN, mispCount increments by 1.
